// File: rtl/game_pkg.sv
// Shared playfield constants, FSM encoding and small helpers for the note scroller and the
// downstream StateHandler stage.
package game_pkg;

  localparam int unsigned LANES   = 4;
  localparam int unsigned ROWS    = 12;
  localparam int unsigned BOARD_W = LANES * ROWS;

  // Feedback taps x^16 + x^14 + x^13 + x^11 + 1 as bit positions 15, 13, 12, 10.
  localparam logic [15:0] LFSR_TAPS    = 16'hB400;
  localparam logic [15:0] DEFAULT_SEED = 16'hACE1;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StRun   = 2'd1,
    StPause = 2'd2
  } state_e;

  function automatic logic [2:0] popcount4(input logic [3:0] v);
    popcount4 = 3'(v[0]) + 3'(v[1]) + 3'(v[2]) + 3'(v[3]);
  endfunction

  function automatic logic [LANES-1:0] lane_onehot(input logic [1:0] sel);
    lane_onehot = LANES'(1) << sel;
  endfunction

endpackage

// File: rtl/note_scroller_if.sv
// Control and playfield signals between the note scroller and the StateHandler stage.
interface note_scroller_if;
  import game_pkg::*;

  logic               enable;
  logic [LANES-1:0]   clear_col;
  logic [BOARD_W-1:0] square_locations;
  logic               step;
  logic [LANES-1:0]   miss;
  logic [7:0]         miss_count;

  modport master (
    output enable, clear_col,
    input  square_locations, step, miss, miss_count
  );

  modport slave (
    input  enable, clear_col,
    output square_locations, step, miss, miss_count
  );
endinterface

// File: rtl/note_lfsr.sv
// 16-bit Fibonacci LFSR that picks spawn lanes; loads the seed on reset and advances on request.
module note_lfsr import game_pkg::*; (
  input  logic        clk,
  input  logic        rst,
  input  logic        advance_i,
  input  logic [15:0] seed_i,
  output logic [15:0] value_o
);
  logic [15:0] lfsr_q, lfsr_d;

  always_comb begin
    lfsr_d = lfsr_q;
    if (advance_i) begin
      lfsr_d = {lfsr_q[14:0], ^(lfsr_q & LFSR_TAPS)};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      lfsr_q <= seed_i;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign value_o = lfsr_q;
endmodule

// File: rtl/note_scroller.sv
// Falling-note playfield: scrolls a 12x4 board toward the hit row every TICK_DIV clocks,
// spawns notes from an LFSR, applies lane clears and reports uncleared notes as misses.
module note_scroller import game_pkg::*; #(
  parameter int unsigned TICK_DIV  = 25000000,
  parameter int unsigned SPAWN_GAP = 2,
  parameter logic [15:0] LFSR_SEED = game_pkg::DEFAULT_SEED
) (
  input logic            clk,
  input logic            rst,
  note_scroller_if.slave bus
);
  localparam int unsigned TickW  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned SpawnW = (SPAWN_GAP > 1) ? $clog2(SPAWN_GAP) : 1;
  localparam logic [TickW-1:0]  TickLast  = TickW'(TICK_DIV - 1);
  localparam logic [SpawnW-1:0] SpawnLast = SpawnW'(SPAWN_GAP - 1);

  state_e             state_q, state_d;
  logic [TickW-1:0]   tick_q, tick_d;
  logic [SpawnW-1:0]  spawn_q, spawn_d;
  logic [BOARD_W-1:0] board_q, board_d;
  logic               step_q, step_d;
  logic [LANES-1:0]   miss_q, miss_d;
  logic [7:0]         miss_cnt_q, miss_cnt_d;

  logic               lfsr_adv;
  logic [15:0]        lfsr_value;
  logic [BOARD_W-1:0] cleared;
  logic [8:0]         miss_sum;
  logic               unused_lfsr;

  note_lfsr u_lfsr (
    .clk       (clk),
    .rst       (rst),
    .advance_i (lfsr_adv),
    .seed_i    (LFSR_SEED),
    .value_o   (lfsr_value)
  );

  // Only the two low LFSR bits select a spawn lane.
  assign unused_lfsr = ^lfsr_value[15:2];

  // Clear only ever touches the hit row.
  assign cleared  = board_q & ~{{(BOARD_W - LANES){1'b0}}, bus.clear_col};
  assign miss_sum = {1'b0, miss_cnt_q} + {6'b0, popcount4(cleared[LANES-1:0])};

  always_comb begin
    state_d    = state_q;
    tick_d     = tick_q;
    spawn_d    = spawn_q;
    board_d    = board_q;
    step_d     = 1'b0;
    miss_d     = '0;
    miss_cnt_d = miss_cnt_q;
    lfsr_adv   = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (bus.enable) state_d = StRun;
      end
      StRun: begin
        if (!bus.enable) state_d = StPause;
        board_d = cleared;
        if (tick_q == TickLast) begin
          tick_d     = '0;
          step_d     = 1'b1;
          miss_d     = cleared[LANES-1:0];
          miss_cnt_d = miss_sum[8] ? 8'hFF : miss_sum[7:0];
          // Row 11 is empty after the shift, so the spawn can simply overwrite it.
          board_d    = cleared >> LANES;
          if (spawn_q == '0) begin
            board_d[BOARD_W-1 -: LANES] = lane_onehot(lfsr_value[1:0]);
          end
          spawn_d    = (spawn_q == SpawnLast) ? '0 : spawn_q + 1'b1;
          lfsr_adv   = 1'b1;
        end else begin
          tick_d = tick_q + 1'b1;
        end
      end
      StPause: begin
        if (bus.enable) state_d = StRun;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= StIdle;
      tick_q     <= '0;
      spawn_q    <= '0;
      board_q    <= '0;
      step_q     <= 1'b0;
      miss_q     <= '0;
      miss_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      tick_q     <= tick_d;
      spawn_q    <= spawn_d;
      board_q    <= board_d;
      step_q     <= step_d;
      miss_q     <= miss_d;
      miss_cnt_q <= miss_cnt_d;
    end
  end

  assign bus.square_locations = board_q;
  assign bus.step             = step_q;
  assign bus.miss             = miss_q;
  assign bus.miss_count       = miss_cnt_q;
endmodule
